display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter: PRESCALE, default 50000, clk cycles per digit slot; legal minimum 2.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 value_in  input  16  four hex nibbles; nibble i drives digit i, with digit 0 the least significant.
REQ-005 blank_lz  input  1  leading-zero blanking request, captured with value_in.
REQ-006 value_valid  input  1  producer offers value_in/blank_lz.
REQ-007 value_ready  output  1  block can accept a value this cycle.
REQ-008 digit_code  output  4  nibble for the 7-segment decoder's display_in.
REQ-009 digit_dp  output  1  decoder dp input; 1 = blank digit (decoder drives all segments off).
REQ-010 digit_en  output  4  one-hot, active-high common select for the digit currently shown.

Function
REQ-011 A prescaler SHALL count 0..PRESCALE-1 and wrap; a one-cycle tick SHALL occur in the cycle the count equals PRESCALE-1.
REQ-012 A 2-bit digit index SHALL advance 0->1->2->3->0 on each tick; each digit is therefore shown for exactly PRESCALE cycles.
REQ-013 The index wrap from 3 to 0 SHALL be the frame boundary.
REQ-014 Two 17-bit registers SHALL hold state: active (shown value + blank flag) and pending (next value + blank flag), plus a pending_full flag.
REQ-015 value_ready SHALL equal NOT pending_full, driven combinationally from the registered flag.
REQ-016 A transfer SHALL occur when value_valid and value_ready are both 1; it loads pending and sets pending_full on that edge.
REQ-017 When pending_full is 1 at the frame-boundary tick, pending SHALL be copied into active and pending_full SHALL clear on that edge.
REQ-018 A transfer in the same cycle as a frame-boundary tick with pending_full = 0 SHALL be held in pending and committed at the next frame boundary, never mid-frame.
REQ-019 A value SHALL never be dropped: value_in is ignored while value_ready is 0.
REQ-020 Digit i SHALL be blanked when the active blank flag is 1, i is not 0, and active nibbles i..3 are all zero; digit 0 SHALL never be blanked.
REQ-021 For a blanked digit, digit_code SHALL be 4'h0 and digit_dp SHALL be 1; otherwise digit_code SHALL be active nibble i and digit_dp SHALL be 0.
REQ-022 digit_code, digit_dp and digit_en SHALL be registered and SHALL change on the same edge as the index, reflecting the new index and the active value in effect after that edge.
REQ-023 digit_en SHALL have exactly one bit set at all times, bit i for index i.

Reset
REQ-024 While rst = 1, the following values SHALL hold asynchronously: prescaler 0, index 0, active 0, pending 0, pending_full 0.
REQ-025 While rst = 1, outputs SHALL be value_ready = 1, digit_en = 4'b0001, digit_code = 4'h0, digit_dp = 0.
REQ-026 After rst deasserts, the first tick SHALL occur PRESCALE cycles later.
REQ-027 A reset mid-frame or mid-transfer SHALL discard the pending and active values.

Structure
REQ-028 Package display_pkg SHALL hold the constants NUM_DIGITS = 4, DIGIT_W = 4 and BLANK_DP = 1'b1.
REQ-029 The prescaler SHALL be a sub-module tick_gen (parameter PRESCALE, ports clk, rst, tick).
REQ-030 display_scan output feeds the existing 7-segment decoder directly; no segment decoding SHALL occur in this block.

Verification (PRESCALE = 4)
REQ-031 Scenario: load 16'h12AF with blank_lz = 0.
- Required response: from the next frame boundary, codes F,A,2,1 appear with digit_en 0001,0010,0100,1000, each held 4 cycles, and dp = 0.
REQ-032 Scenario: load 16'h0030 with blank_lz = 1.
- Required response: digits 3 and 2 show code 0 with dp = 1, digit 1 shows code 3 with dp = 0, digit 0 shows code 0 with dp = 0.
- Also: load 16'h0000 with blank_lz = 1; only digit 0 is unblanked.
REQ-033 Scenario: back-to-back valid with 16'h1111 then 16'h2222.
- Required response: the first is accepted, value_ready falls, and the second is held until the commit edge.
- Then 1111 shows for one frame and 2222 from the following frame.
REQ-034 Scenario: transfer of 16'h5555 in the frame-boundary tick cycle with pending empty.
- Required response: 5555 is not shown in the frame starting at that edge; it is shown from the next frame.
REQ-035 Scenario: assert rst mid-frame at index 2 with pending_full = 1.
- Required response: outputs go immediately to the reset values, value_ready = 1, and after release the display shows code 0 on digit 0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared constants, value record and blanking rule for the digit scanner
package display_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W = 4;
    localparam logic BLANK_DP = 1'b1;
    localparam int VALUE_W = NUM_DIGITS * DIGIT_W;

    typedef struct packed {
        logic blank;
        logic [VALUE_W-1:0] value;
    } disp_t;

    // A digit is blanked when it and every more significant nibble are zero
    function automatic logic is_blank(disp_t d, logic [1:0] i);
        return d.blank && (i != 2'd0) && ((d.value >> (DIGIT_W * i)) == '0);
    endfunction
endpackage

// File: rtl/display_scan_if.sv
// display_scan_if: value handshake from the producer and scan outputs to the segment decoder
interface display_scan_if;
    import display_pkg::*;
    logic [VALUE_W-1:0] value_in;
    logic blank_lz;
    logic value_valid;
    logic value_ready;
    logic [DIGIT_W-1:0] digit_code;
    logic digit_dp;
    logic [NUM_DIGITS-1:0] digit_en;

    modport master(output value_in, blank_lz, value_valid,
                   input value_ready, digit_code, digit_dp, digit_en);
    modport slave(input value_in, blank_lz, value_valid,
                  output value_ready, digit_code, digit_dp, digit_en);
endinterface

// File: rtl/display_scan_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every PRESCALE clocks
module tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(PRESCALE);
    logic [W-1:0] cnt;

    assign tick = cnt == W'(PRESCALE - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/display_scan.sv
// display_scan: multiplexes four hex digits with frame-aligned double-buffered value updates
module display_scan
    import display_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    display_scan_if.slave bus
);
    logic tick, frame, commit, xfer, blank_nxt;
    logic [1:0] idx, idx_nxt;
    disp_t active, pending, active_nxt;
    logic pending_full;
    logic [DIGIT_W-1:0] code_q;
    logic dp_q;
    logic [NUM_DIGITS-1:0] en_q;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    assign bus.value_ready = !pending_full;
    assign bus.digit_code = code_q;
    assign bus.digit_dp = dp_q;
    assign bus.digit_en = en_q;

    // Outputs are computed for the index and active value that take effect on this edge
    always_comb begin
        frame = tick && (idx == 2'd3);
        commit = frame && pending_full;
        xfer = bus.value_valid && !pending_full;
        idx_nxt = tick ? idx + 2'd1 : idx;
        active_nxt = commit ? pending : active;
        blank_nxt = is_blank(active_nxt, idx_nxt);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx <= '0;
            active <= '0;
            pending <= '0;
            pending_full <= 1'b0;
            code_q <= '0;
            dp_q <= 1'b0;
            en_q <= NUM_DIGITS'(1);
        end else begin
            idx <= idx_nxt;
            active <= active_nxt;
            if (commit) pending_full <= 1'b0;
            else if (xfer) begin
                pending <= {bus.blank_lz, bus.value_in};
                pending_full <= 1'b1;
            end
            if (tick) begin
                en_q <= NUM_DIGITS'(1) << idx_nxt;
                code_q <= blank_nxt ? '0 : active_nxt.value[DIGIT_W*idx_nxt +: DIGIT_W];
                dp_q <= blank_nxt ? BLANK_DP : ~BLANK_DP;
            end
        end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: randomized and directed checks of display_scan against a cycle-count reference model
module tb_display_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int m_edges;
    logic [16:0] m_active, m_pend;
    logic m_full, m_took;
    logic [9:0] obs, exp_v;

    display_scan_if bus();
    display_scan #(.PRESCALE(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Time-based model: edges since reset, 4 per digit, 16 per frame
    always @(posedge clk or posedge rst)
        if (rst) begin
            m_edges <= 0;
            m_active <= '0;
            m_pend <= '0;
            m_full <= 1'b0;
            m_took <= 1'b0;
        end else begin
            m_edges <= m_edges + 1;
            m_took <= bus.value_valid && !m_full;
            if (((m_edges + 1) % 16 == 0) && m_full) begin
                m_active <= m_pend;
                m_full <= 1'b0;
            end else if (bus.value_valid && !m_full) begin
                m_pend <= {bus.blank_lz, bus.value_in};
                m_full <= 1'b1;
            end
        end

    function automatic logic [9:0] exp_out();
        int d;
        logic [3:0] nib;
        logic [15:0] hi;
        logic blk;
        d = (m_edges / 4) % 4;
        nib = m_active[4*d +: 4];
        hi = m_active[15:0] >> (4 * d);
        blk = m_active[16] && d != 0 && hi == 16'h0;
        return {!m_full, 4'(1 << d), blk, blk ? 4'h0 : nib};
    endfunction

    task automatic test_reset();
        bus.value_valid = 1'b0;
        bus.value_in = '0;
        bus.blank_lz = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs = {bus.value_ready, bus.digit_en, bus.digit_dp, bus.digit_code};
        n_cmp++;
        if (obs !== 10'b1_0001_0_0000) begin
            n_bad++;
            $display("FAIL reset_state got %b required %b", obs, 10'b1_0001_0_0000);
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            obs = {bus.value_ready, bus.digit_en, bus.digit_dp, bus.digit_code};
            exp_v = exp_out();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL after_reset t=%0t got %b required %b", $time, obs, exp_v);
            end
        end
    endtask

    task automatic test_load(input logic [15:0] v, input logic b, input string name);
        int guard = 0;
        while (m_full && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (m_full) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_wait got pending_full 1 required 0", name);
        end
        bus.value_in = v;
        bus.blank_lz = b;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
        n_cmp++;
        if (bus.value_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_accept got ready %b required 0", name, bus.value_ready);
        end
        repeat (40) begin
            @(negedge clk);
            obs = {bus.value_ready, bus.digit_en, bus.digit_dp, bus.digit_code};
            exp_v = exp_out();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL %s t=%0t got %b required %b", name, $time, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] items[2] = '{16'h1111, 16'h2222};
        int k = 0;
        int guard = 0;
        bus.value_in = items[0];
        bus.blank_lz = 1'b0;
        bus.value_valid = 1'b1;
        while (guard < 80) begin
            @(negedge clk);
            guard++;
            obs = {bus.value_ready, bus.digit_en, bus.digit_dp, bus.digit_code};
            exp_v = exp_out();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL back_to_back t=%0t got %b required %b", $time, obs, exp_v);
            end
            if (m_took) begin
                k++;
                if (k == 2) bus.value_valid = 1'b0;
                else bus.value_in = items[1];
            end
        end
        n_cmp++;
        if (k != 2) begin
            n_bad++;
            $display("FAIL back_to_back_count got %0d accepted required 2", k);
        end
    endtask

    task automatic test_boundary();
        int guard = 0;
        while (!(m_full == 1'b0 && (m_edges + 1) % 16 == 0) && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (m_full || (m_edges + 1) % 16 != 0) begin
            n_bad++;
            $display("FAIL boundary_align got edge %0d required frame tick cycle", m_edges);
        end
        bus.value_in = 16'h5555;
        bus.blank_lz = 1'b0;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
        n_cmp++;
        if (bus.digit_code === 4'h5) begin
            n_bad++;
            $display("FAIL boundary_early got code %h required not 5", bus.digit_code);
        end
        repeat (36) begin
            @(negedge clk);
            obs = {bus.value_ready, bus.digit_en, bus.digit_dp, bus.digit_code};
            exp_v = exp_out();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL boundary t=%0t got %b required %b", $time, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            @(negedge clk);
            obs = {bus.value_ready, bus.digit_en, bus.digit_dp, bus.digit_code};
            exp_v = exp_out();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL random t=%0t got %b required %b", $time, obs, exp_v);
            end
            bus.value_valid = $urandom_range(0, 5) == 0;
            bus.value_in = 16'($urandom >> (16 + 4 * $urandom_range(0, 4)));
            bus.blank_lz = 1'($urandom);
        end
        bus.value_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(m_full && (m_edges / 4) % 4 == 2) && guard < 80) begin
            @(negedge clk);
            guard++;
            if (!m_full && (m_edges / 4) % 4 == 0) begin
                bus.value_in = 16'h9876;
                bus.blank_lz = 1'b0;
                bus.value_valid = 1'b1;
            end else bus.value_valid = 1'b0;
        end
        bus.value_valid = 1'b0;
        n_cmp++;
        if (!(m_full && (m_edges / 4) % 4 == 2)) begin
            n_bad++;
            $display("FAIL reset_mid_setup got edge %0d full %b required index 2 full 1", m_edges, m_full);
        end
        #1 rst = 1'b1;
        #1;
        obs = {bus.value_ready, bus.digit_en, bus.digit_dp, bus.digit_code};
        n_cmp++;
        if (obs !== 10'b1_0001_0_0000) begin
            n_bad++;
            $display("FAIL reset_mid_async got %b required %b", obs, 10'b1_0001_0_0000);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (24) begin
            @(negedge clk);
            obs = {bus.value_ready, bus.digit_en, bus.digit_dp, bus.digit_code};
            exp_v = exp_out();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset_mid_after t=%0t got %b required %b", $time, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load(16'h12AF, 1'b0, "load_12af");
        test_load(16'h0030, 1'b1, "blank_0030");
        test_load(16'h0000, 1'b1, "blank_0000");
        test_back_to_back();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
